// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: sequential AXI4-Lite read master feeding a DEPTH-entry prefetch queue.
// A redirect flushes the queue and discards any response still in flight.
module ifu_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic              out_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_araddr;
    logic               r_drop;
    logic               r_halt;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;

    logic [ADDR_W-1:0]  r_mem_pc   [DEPTH];
    logic [DATA_W-1:0]  r_mem_inst [DEPTH];
    logic               r_mem_err  [DEPTH];

    logic               w_push;
    logic               w_pop;
    logic               w_resp_ok;
    logic               w_issue;
    logic               w_load_ar;
    logic               w_drop_nxt;
    logic               w_halt_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [ADDR_W-1:0]  w_fetch_pc_nxt;

    assign w_resp_ok = (rresp == 2'b00);
    assign w_push    = (r_state == S_R) && rvalid && !r_drop && !redirect_valid;
    assign w_pop     = out_valid && out_ready && !redirect_valid;

    always_comb begin
        w_count_nxt    = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_fetch_pc_nxt = r_fetch_pc;
        w_halt_nxt     = r_halt;
        if (w_push && w_resp_ok) begin
            w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(4);
        end
        if (w_push && !w_resp_ok) begin
            w_halt_nxt = 1'b1;
        end
        if (redirect_valid) begin
            w_count_nxt    = '0;
            w_fetch_pc_nxt = redirect_pc;
            w_halt_nxt     = 1'b0;
        end
    end

    // Credit check uses post-cycle occupancy, so the single outstanding fetch always has a slot.
    assign w_issue = fetch_en && !w_halt_nxt && !redirect_valid && (w_count_nxt < CNT_W'(DEPTH));

    always_comb begin
        w_state_nxt = r_state;
        w_load_ar   = 1'b0;
        w_drop_nxt  = r_drop;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = S_AR;
                    w_load_ar   = 1'b1;
                end
            end
            S_AR: begin
                if (redirect_valid) begin
                    w_drop_nxt = 1'b1;
                end
                if (arready) begin
                    w_state_nxt = S_R;
                end
            end
            S_R: begin
                if (rvalid) begin
                    w_drop_nxt = 1'b0;
                    if (w_issue) begin
                        w_state_nxt = S_AR;
                        w_load_ar   = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (redirect_valid) begin
                    w_drop_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_araddr   <= RESET_PC;
            r_drop     <= 1'b0;
            r_halt     <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_drop     <= w_drop_nxt;
            r_halt     <= w_halt_nxt;
            r_count    <= w_count_nxt;
            if (w_load_ar) begin
                r_araddr <= w_fetch_pc_nxt;
            end
            if (redirect_valid) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_araddr;
            r_mem_inst[r_wr_ptr] <= rdata;
            r_mem_err[r_wr_ptr]  <= !w_resp_ok;
        end
    end

    assign arvalid   = (r_state == S_AR);
    assign rready    = (r_state == S_R);
    assign araddr    = r_araddr;
    assign out_valid = (r_count != '0);
    assign out_pc    = out_valid ? r_mem_pc[r_rd_ptr]   : '0;
    assign out_inst  = out_valid ? r_mem_inst[r_rd_ptr] : '0;
    assign out_err   = out_valid ? r_mem_err[r_rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: a zero-wait AXI4-Lite slave answers rdata = ~addr,
// and the popped {pc, err} stream is recorded for ordering checks.
module tb_ifu_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;

    logic        ar_en = 1'b1;
    logic        r_en = 1'b1;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    int          n_ar;
    int          n_r;
    int          n_vec = 0;
    int          n_mis = 0;
    logic [31:0] pc_q[$];
    logic        err_q[$];

    ifu_fetch_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_err        (out_err),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Slave: responds in the cycle after the AR handshake unless r_en holds it off.
    always @(negedge clk) begin
        arready = ar_en;
        if (rready && r_en) begin
            rvalid = 1'b1;
            rdata  = araddr ^ 32'hFFFF_FFFF;
            rresp  = (araddr == err_addr) ? 2'b10 : 2'b00;
        end else begin
            rvalid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            pc_q.push_back(out_pc);
            err_q.push_back(out_err);
            check("inst", {32'h0, out_inst}, {32'h0, out_pc ^ 32'hFFFF_FFFF});
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_ar <= 0;
            n_r  <= 0;
        end else begin
            if (arvalid && arready) n_ar <= n_ar + 1;
            if (rvalid && rready)   n_r  <= n_r + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst_n          = 1'b0;
        fetch_en       = 1'b1;
        out_ready      = rdy;
        ar_en          = 1'b1;
        r_en           = 1'b1;
        redirect_valid = 1'b0;
        err_addr       = 32'hFFFF_FFFF;
        pc_q.delete();
        err_q.delete();
        tick;
        tick;
    endtask

    task automatic wait_r(input int n, input int budget);
        int k = 0;
        while (n_r < n && k < budget) begin
            tick;
            k++;
        end
        check("wait_r", 64'(n_r >= n), 64'd1);
    endtask

    task automatic wait_pops(input int n, input int budget);
        int k = 0;
        while (pc_q.size() < n && k < budget) begin
            tick;
            k++;
        end
        check("wait_pops", 64'(pc_q.size() >= n), 64'd1);
    endtask

    initial begin
        // 1: reset values, first-entry latency, in-order sequential fetch
        do_reset(1'b1);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_rready", 64'(rready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_araddr", 64'(araddr), 64'h8000_0000);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        rst_n = 1'b1;
        tick;
        check("t1_valid_c1", 64'(out_valid), 64'd0);
        check("t1_arvalid_c1", 64'(arvalid), 64'd1);
        tick;
        check("t1_valid_c2", 64'(out_valid), 64'd0);
        tick;
        check("t1_valid_c3", 64'(out_valid), 64'd1);
        check("t1_pc_c3", 64'(out_pc), 64'h8000_0000);
        wait_pops(6, 60);
        for (int i = 0; i < 6 && i < pc_q.size(); i++) begin
            check("t1_seq", 64'(pc_q[i]), 64'(32'h8000_0000 + 32'(4 * i)));
        end

        // 2: backpressure fills exactly DEPTH entries, then drains without loss
        do_reset(1'b0);
        rst_n = 1'b1;
        repeat (30) tick;
        check("t2_n_ar", 64'(n_ar), 64'd4);
        check("t2_arvalid", 64'(arvalid), 64'd0);
        check("t2_head", 64'(out_pc), 64'h8000_0000);
        out_ready = 1'b1;
        wait_pops(10, 100);
        for (int i = 0; i < 10 && i < pc_q.size(); i++) begin
            check("t2_seq", 64'(pc_q[i]), 64'(32'h8000_0000 + 32'(4 * i)));
        end

        // 3: redirect while AR is stalled; araddr stays put, response dropped
        do_reset(1'b0);
        ar_en = 1'b0;
        rst_n = 1'b1;
        tick;
        check("t3_araddr_c1", 64'(araddr), 64'h8000_0000);
        tick;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick;
        redirect_valid = 1'b0;
        check("t3_araddr_c3", 64'(araddr), 64'h8000_0000);
        check("t3_arvalid_c3", 64'(arvalid), 64'd1);
        tick;
        tick;
        check("t3_araddr_c5", 64'(araddr), 64'h8000_0000);
        ar_en = 1'b1;
        tick;
        tick;
        check("t3_drop_valid", 64'(out_valid), 64'd0);
        check("t3_next_araddr", 64'(araddr), 64'h8000_0100);
        begin
            int k = 0;
            while (!out_valid && k < 20) begin
                tick;
                k++;
            end
        end
        check("t3_valid", 64'(out_valid), 64'd1);
        check("t3_pc", 64'(out_pc), 64'h8000_0100);

        // 4: redirect coincides with rvalid while 3 entries are queued
        do_reset(1'b0);
        rst_n = 1'b1;
        wait_r(3, 40);
        r_en = 1'b0;
        tick;
        tick;
        check("t4_rready", 64'(rready), 64'd1);
        check("t4_valid_pre", 64'(out_valid), 64'd1);
        r_en           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick;
        redirect_valid = 1'b0;
        check("t4_valid_post", 64'(out_valid), 64'd0);
        check("t4_arvalid_post", 64'(arvalid), 64'd0);
        tick;
        check("t4_arvalid", 64'(arvalid), 64'd1);
        check("t4_araddr", 64'(araddr), 64'h8000_0200);
        out_ready = 1'b1;
        pc_q.delete();
        err_q.delete();
        wait_pops(1, 20);
        if (pc_q.size() > 0) check("t4_pc", 64'(pc_q[0]), 64'h8000_0200);

        // 5: error response halts fetch; redirect restarts it
        do_reset(1'b0);
        err_addr = 32'h8000_0008;
        rst_n = 1'b1;
        repeat (30) tick;
        check("t5_n_ar", 64'(n_ar), 64'd3);
        check("t5_arvalid", 64'(arvalid), 64'd0);
        out_ready = 1'b1;
        repeat (10) tick;
        check("t5_pops", 64'(pc_q.size()), 64'd3);
        if (pc_q.size() >= 3) begin
            check("t5_err_pc", 64'(pc_q[2]), 64'h8000_0008);
            check("t5_err_flag", 64'(err_q[2]), 64'd1);
            check("t5_ok_flag", 64'(err_q[1]), 64'd0);
        end
        err_addr = 32'hFFFF_FFFF;
        pc_q.delete();
        err_q.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0000;
        tick;
        redirect_valid = 1'b0;
        wait_pops(2, 40);
        if (pc_q.size() >= 2) begin
            check("t5_restart0", 64'(pc_q[0]), 64'h8000_0000);
            check("t5_restart1", 64'(pc_q[1]), 64'h8000_0004);
            check("t5_restart_err", 64'(err_q[0]), 64'd0);
        end

        // 6: asynchronous reset in state R with 2 entries queued
        do_reset(1'b0);
        rst_n = 1'b1;
        wait_r(2, 40);
        r_en = 1'b0;
        tick;
        tick;
        check("t6_rready_pre", 64'(rready), 64'd1);
        check("t6_valid_pre", 64'(out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_arvalid", 64'(arvalid), 64'd0);
        check("t6_rready", 64'(rready), 64'd0);
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_araddr", 64'(araddr), 64'h8000_0000);
        tick;
        rst_n     = 1'b1;
        r_en      = 1'b1;
        out_ready = 1'b1;
        pc_q.delete();
        err_q.delete();
        wait_pops(2, 40);
        if (pc_q.size() >= 2) begin
            check("t6_pc0", 64'(pc_q[0]), 64'h8000_0000);
            check("t6_pc1", 64'(pc_q[1]), 64'h8000_0004);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
